siw_bram_burst_reader: RTL and testbench

- Read initiator for one port of a siw_memory_bram_* dual-port memory wrapper.
- Accepts a burst command (base, length, stride) and drives the memory port's enable, write-enable and address pins.
- Absorbs the fixed read latency (memory array plus output register) and presents the returned words as a valid/ready stream with a last flag.
- Sits between the sequencer and the memory, the consumer-side counterpart of the memory's port.

---
 rtl/siw_bram_burst_reader_if.sv | 36 +++
 rtl/siw_bram_burst_reader.sv | 221 ++++++++++++++++++++++
 tb/tb_siw_bram_burst_reader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/siw_bram_burst_reader_if.sv
// rtl/siw_bram_burst_reader_if.sv - memory-port and output-stream bundle for siw_bram_burst_reader
interface siw_bram_burst_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              siw_bram_burst_reader_mem_enable;
    logic              siw_bram_burst_reader_mem_write_en;
    logic [ADDR_W-1:0] siw_bram_burst_reader_mem_address;
    logic [DATA_W-1:0] siw_bram_burst_reader_mem_data;
    logic [DATA_W-1:0] siw_bram_burst_reader_out_data;
    logic              siw_bram_burst_reader_out_valid;
    logic              siw_bram_burst_reader_out_ready;
    logic              siw_bram_burst_reader_out_last;

    modport master (
        output siw_bram_burst_reader_mem_enable,
        output siw_bram_burst_reader_mem_write_en,
        output siw_bram_burst_reader_mem_address,
        input  siw_bram_burst_reader_mem_data,
        output siw_bram_burst_reader_out_data,
        output siw_bram_burst_reader_out_valid,
        input  siw_bram_burst_reader_out_ready,
        output siw_bram_burst_reader_out_last
    );

    modport slave (
        input  siw_bram_burst_reader_mem_enable,
        input  siw_bram_burst_reader_mem_write_en,
        input  siw_bram_burst_reader_mem_address,
        output siw_bram_burst_reader_mem_data,
        input  siw_bram_burst_reader_out_data,
        input  siw_bram_burst_reader_out_valid,
        output siw_bram_burst_reader_out_ready,
        input  siw_bram_burst_reader_out_last
    );
endinterface

// File: rtl/siw_bram_burst_reader.sv
// rtl/siw_bram_burst_reader.sv - burst read initiator for one BRAM port with credit-managed output FIFO
// Optional SIW_BRAM_BURST_READER_STRIDE_EN adds a stride input; otherwise the address step is 1.
module siw_bram_burst_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              siw_bram_burst_reader_clk,
    input  logic              siw_bram_burst_reader_reset_n,
    input  logic              siw_bram_burst_reader_start,
    input  logic [ADDR_W-1:0] siw_bram_burst_reader_base,
    input  logic [ADDR_W:0]   siw_bram_burst_reader_length,
`ifdef SIW_BRAM_BURST_READER_STRIDE_EN
    input  logic [ADDR_W-1:0] siw_bram_burst_reader_stride,
`endif
    input  logic              siw_bram_burst_reader_abort,
    output logic              siw_bram_burst_reader_busy,
    output logic              siw_bram_burst_reader_done,
    siw_bram_burst_reader_if.master bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LEN_W  = ADDR_W + 1;
    localparam int FL_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int USED_W = $clog2(FIFO_DEPTH + READ_LAT + 2) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE,
        S_ABORT_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_enable_q, mem_enable_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    remain_q, remain_d;
    logic [LEN_W-1:0]    cap_cnt_q, cap_cnt_d;
    logic [READ_LAT-1:0] pipe_q, pipe_d;
    logic [FL_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    fifo_count_q, fifo_count_d;

    logic [ADDR_W-1:0]   step;
    logic                accept;
    logic                out_valid;
    logic                pop;
    logic                push;
    logic                flush;
    logic                credit_ok;
    logic [USED_W-1:0]   used;

    assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                    siw_bram_burst_reader_start && (siw_bram_burst_reader_length != '0);

`ifdef SIW_BRAM_BURST_READER_STRIDE_EN
    logic [ADDR_W-1:0] stride_q, stride_d;

    always_comb begin
        stride_d = stride_q;
        if (accept) stride_d = siw_bram_burst_reader_stride;
    end

    always_ff @(posedge siw_bram_burst_reader_clk or negedge siw_bram_burst_reader_reset_n) begin
        if (!siw_bram_burst_reader_reset_n) stride_q <= '0;
        else                                stride_q <= stride_d;
    end

    assign step = stride_q;
`else
    assign step = ADDR_W'(1);
`endif

    assign out_valid = (fifo_count_q != '0);
    assign pop       = out_valid && bus.siw_bram_burst_reader_out_ready;
    assign push      = pipe_q[READ_LAT-1] && (state_q != S_ABORT_FLUSH);

    // Credits cover words already buffered plus every read still in the memory pipe.
    always_comb begin
        used = USED_W'(fifo_count_q) + USED_W'(mem_enable_q);
        for (int i = 0; i < READ_LAT; i++) used = used + USED_W'(pipe_q[i]);
        credit_ok = (used - USED_W'(pop)) < USED_W'(FIFO_DEPTH);
    end

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        mem_enable_d  = 1'b0;
        mem_address_d = mem_address_q;
        len_d         = len_q;
        remain_d      = remain_q;
        cap_cnt_d     = cap_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        flush         = 1'b0;
        fifo_data_d   = fifo_data_q;
        fifo_last_d   = fifo_last_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fifo_count_d  = fifo_count_q;

        pipe_d[0] = mem_enable_q;
        for (int i = 1; i < READ_LAT; i++) pipe_d[i] = pipe_q[i-1];

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    busy_d        = 1'b1;
                    mem_enable_d  = 1'b1;
                    mem_address_d = siw_bram_burst_reader_base;
                    len_d         = siw_bram_burst_reader_length;
                    remain_d      = siw_bram_burst_reader_length - LEN_W'(1);
                    cap_cnt_d     = '0;
                    state_d       = (siw_bram_burst_reader_length == LEN_W'(1)) ? S_DRAIN : S_ISSUE;
                end else if (siw_bram_burst_reader_start) begin
                    done_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (siw_bram_burst_reader_abort) begin
                    flush = 1'b1;
                end else if ((remain_q != '0) && credit_ok) begin
                    mem_enable_d  = 1'b1;
                    mem_address_d = mem_address_q + step;
                    remain_d      = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (siw_bram_burst_reader_abort) begin
                    flush = 1'b1;
                end else if (pop && fifo_last_q[rd_ptr_q]) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_ABORT_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FL_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d      = S_ABORT_FLUSH;
            flush_cnt_d  = FL_W'(READ_LAT - 1);
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            fifo_count_d = '0;
        end else begin
            if (push) begin
                fifo_data_d[wr_ptr_q] = bus.siw_bram_burst_reader_mem_data;
                fifo_last_d[wr_ptr_q] = (cap_cnt_q == (len_q - LEN_W'(1)));
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                cap_cnt_d             = cap_cnt_q + LEN_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge siw_bram_burst_reader_clk or negedge siw_bram_burst_reader_reset_n) begin
        if (!siw_bram_burst_reader_reset_n) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_address_q <= '0;
            len_q         <= '0;
            remain_q      <= '0;
            cap_cnt_q     <= '0;
            pipe_q        <= '0;
            flush_cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
            fifo_last_q   <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fifo_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mem_enable_q  <= mem_enable_d;
            mem_address_q <= mem_address_d;
            len_q         <= len_d;
            remain_q      <= remain_d;
            cap_cnt_q     <= cap_cnt_d;
            pipe_q        <= pipe_d;
            flush_cnt_q   <= flush_cnt_d;
            fifo_data_q   <= fifo_data_d;
            fifo_last_q   <= fifo_last_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fifo_count_q  <= fifo_count_d;
        end
    end

    assign siw_bram_burst_reader_busy         = busy_q;
    assign siw_bram_burst_reader_done         = done_q;
    assign bus.siw_bram_burst_reader_mem_enable   = mem_enable_q;
    assign bus.siw_bram_burst_reader_mem_write_en = 1'b0;
    assign bus.siw_bram_burst_reader_mem_address  = mem_address_q;
    assign bus.siw_bram_burst_reader_out_valid    = out_valid;
    assign bus.siw_bram_burst_reader_out_last     = out_valid && fifo_last_q[rd_ptr_q];
    assign bus.siw_bram_burst_reader_out_data     = out_valid ? fifo_data_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_siw_bram_burst_reader.sv
// tb/tb_siw_bram_burst_reader.sv - scoreboard bench for siw_bram_burst_reader with a 2-cycle BRAM model
module tb_siw_bram_burst_reader;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   length = '0;
    logic [AW-1:0] stride_v = 10'd1;
    logic          busy, done;
    int            cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    siw_bram_burst_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    siw_bram_burst_reader #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .FIFO_DEPTH(FD)) dut (
        .siw_bram_burst_reader_clk     (clk),
        .siw_bram_burst_reader_reset_n (rst_n),
        .siw_bram_burst_reader_start   (start),
        .siw_bram_burst_reader_base    (base),
        .siw_bram_burst_reader_length  (length),
`ifdef SIW_BRAM_BURST_READER_STRIDE_EN
        .siw_bram_burst_reader_stride  (stride_v),
`endif
        .siw_bram_burst_reader_abort   (abort),
        .siw_bram_burst_reader_busy    (busy),
        .siw_bram_burst_reader_done    (done),
        .bus                           (bus)
    );

    logic          mem_en, mem_we, o_valid, o_last, o_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] o_data, r1, r2;
    assign mem_en   = bus.siw_bram_burst_reader_mem_enable;
    assign mem_we   = bus.siw_bram_burst_reader_mem_write_en;
    assign mem_addr = bus.siw_bram_burst_reader_mem_address;
    assign o_valid  = bus.siw_bram_burst_reader_out_valid;
    assign o_last   = bus.siw_bram_burst_reader_out_last;
    assign o_data   = bus.siw_bram_burst_reader_out_data;
    assign bus.siw_bram_burst_reader_out_ready = o_ready;
    assign bus.siw_bram_burst_reader_mem_data  = r2;

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        return {6'h2B, a, 6'h15, ~a};
    endfunction

    // Array read register then output register: data valid two cycles after the address.
    always @(posedge clk) begin
        if (mem_en) r1 <= memval(mem_addr);
        r2 <= r1;
    end

    int n_tests = 0, n_fail = 0;
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    logic          exp_last[$];
    int  c0, first_en, last_en, first_val, last_cyc, done_cyc, done_cnt = 0;
    int  en_count, issued, popped;
    bit  credit_on = 0, ready_mode = 0, hold_pend = 0;
    logic [DW-1:0] hold_data;
    logic          hold_last;

    initial begin
        o_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            o_ready = ready_mode ? ((cyc % 4) == 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            if (mem_en) begin
                en_count++; issued++; last_en = cyc;
                if (first_en < 0) first_en = cyc;
                if (exp_addr.size() == 0) check("unexpected_issue", 1, 0);
                else check("mem_address", mem_addr, exp_addr.pop_front());
                check("mem_write_en", mem_we, 0);
                if (credit_on) check("credit_bound", (issued - popped) <= FD, 1);
            end
            if (hold_pend) begin
                check("stall_valid", o_valid, 1);
                check("stall_data", o_data, hold_data);
                check("stall_last", o_last, hold_last);
                hold_pend = 0;
            end
            if (o_valid && o_ready) begin
                popped++;
                if (first_val < 0) first_val = cyc;
                if (o_last) last_cyc = cyc;
                if (exp_data.size() == 0) check("unexpected_word", 1, 0);
                else begin
                    check("out_data", o_data, exp_data.pop_front());
                    check("out_last", o_last, exp_last.pop_front());
                end
            end else if (o_valid) begin
                hold_pend = 1; hold_data = o_data; hold_last = o_last;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] len, input logic [AW-1:0] s);
        logic [AW-1:0] a;
        @(posedge clk); #1;
        start = 1'b1; base = b; length = len; stride_v = s;
        c0 = cyc; first_en = -1; last_en = -1; first_val = -1; last_cyc = -1; done_cyc = -1;
        en_count = 0; issued = 0; popped = 0;
        a = b;
        for (int i = 0; i < int'(len); i++) begin
            exp_addr.push_back(a);
            exp_data.push_back(memval(a));
            exp_last.push_back(i == int'(len) - 1);
            a = a + s;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin @(posedge clk); n++; end
        check("done_seen", done_cnt != d0, 1);
        repeat (3) @(posedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("words_left", exp_data.size(), 0);
        check("addrs_left", exp_addr.size(), 0);
    endtask

    task automatic clear_exp();
        exp_addr.delete(); exp_data.delete(); exp_last.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_last"}, o_last, 0);
        check({tag, "_data"}, o_data, 0);
    endtask

    initial begin
        int d0;
        #2;
        check_outputs_zero("reset");
        @(posedge clk); #1; rst_n = 1'b1;

        // Basic burst with exact cycle timing
        do_start(10'h010, 11'd4, 10'd1);
        wait_done(50);
        check("t1_first_en", first_en, c0 + 1);
        check("t1_last_en", last_en, c0 + 4);
        check("t1_first_valid", first_val, c0 + 4);
        check("t1_last_cycle", last_cyc, c0 + 7);
        check("t1_done_cycle", done_cyc, c0 + 8);
        check("t1_busy_after", busy, 0);

        // Address wrap, plus a start strobe while busy that must be ignored
        do_start(10'h3FE, 11'd4, 10'd1);
        start = 1'b1; base = 10'h123; length = 11'd5;
        @(posedge clk); #1; start = 1'b0;
        wait_done(50);

        // Back-pressure: ready 1 cycle in 4
        ready_mode = 1; credit_on = 1;
        do_start(10'h080, 11'd16, 10'd1);
        wait_done(300);
        check("t3_popped", popped, 16);
        ready_mode = 0; credit_on = 0;
        repeat (2) @(posedge clk);

        // Abort three cycles into a long burst
        d0 = done_cnt;
        do_start(10'h100, 11'd32, 10'd1);
        @(posedge clk); #1;
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0; clear_exp();
        @(negedge clk);
        check("abort_mem_en", mem_en, 0);
        check("abort_valid", o_valid, 0);
        check("abort_busy_held", busy, 1);
        @(negedge clk);
        check("abort_busy_lat", busy, 1);
        @(negedge clk);
        check("abort_busy_drop", busy, 0);
        repeat (4) @(posedge clk);
        check("abort_no_done", done_cnt, d0);
        do_start(10'h200, 11'd2, 10'd1);
        wait_done(50);

        // Asynchronous reset in the middle of a burst
        do_start(10'h040, 11'd8, 10'd1);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        clear_exp();
        @(posedge clk); #1;
        @(posedge clk); #1; rst_n = 1'b1;
        do_start(10'h000, 11'd1, 10'd1);
        wait_done(50);
        check("t5_one_word", popped, 1);
        check("t5_last_seen", last_cyc, c0 + 4);

        // Zero-length command
        do_start(10'h055, 11'd0, 10'd1);
        repeat (4) @(posedge clk);
        check("t6_done_cycle", done_cyc, c0 + 1);
        check("t6_no_issue", en_count, 0);
        check("t6_busy", busy, 0);

`ifdef SIW_BRAM_BURST_READER_STRIDE_EN
        do_start(10'h3F0, 11'd3, 10'h020);
        wait_done(50);
        do_start(10'h007, 11'd3, 10'h000);
        wait_done(50);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
